// File: rtl/counter_sweep_seq.sv
// counter_sweep_seq
//   Sequencer for the bounded up/down step counter. It clears the counter,
//   sweeps its direction between the upper and lower saturation points a
//   programmed number of times, and counts double-step (skip) events.
//   It finishes with either a done pulse or a sticky timeout error.
//
// Optional feature: define SEQ_START_DIR_EN to add the start_dir_i input,
//   which selects the direction of the first half-sweep.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        begin a run (sampled in IDLE only)
//   abort_i        cancel a run in CLR/RUN
//   num_sweeps_i   half-sweeps to perform, latched on an accepted start
//   start_dir_i    first-sweep direction (only with SEQ_START_DIR_EN)
//   cnt_limit_i    counter limit flag (0 = saturated)
//   cnt_skip_i     counter skip flag (0 = double step taken)
//   cnt_rst_o      synchronous reset to the counter
//   cnt_mode_o     counter direction (1 = up, 0 = down)
//   busy_o         run in progress (CLR or RUN)
//   done_o         one-cycle pulse on normal completion
//   error_o        sticky timeout flag
//   sweeps_done_o  half-sweeps completed in the current/last run
//   skip_count_o   skip events in the current/last run (saturating)
module counter_sweep_seq #(
   parameter int SWEEP_W = 8,
   parameter int SKIP_W  = 8,
   parameter int TIMEOUT = 512
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [SWEEP_W-1:0] num_sweeps_i,
`ifdef SEQ_START_DIR_EN
   input  logic               start_dir_i,
`endif
   input  logic               cnt_limit_i,
   input  logic               cnt_skip_i,
   output logic               cnt_rst_o,
   output logic               cnt_mode_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o,
   output logic [SWEEP_W-1:0] sweeps_done_o,
   output logic [SKIP_W-1:0]  skip_count_o
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_ERR} state_t;

   state_t             state_q;
   logic [SWEEP_W-1:0] num_q;
   logic [TW-1:0]      timer_q;
   logic               blank_q;
   logic               cnt_rst_q, cnt_mode_q, busy_q, done_q, error_q;
   logic [SWEEP_W-1:0] sweeps_q;
   logic [SKIP_W-1:0]  skip_q;

   logic [TW-1:0]      timer_d;
   logic [SWEEP_W-1:0] sweeps_d;
   logic [SKIP_W-1:0]  skip_d;
   logic               first_dir;

`ifdef SEQ_START_DIR_EN
   assign first_dir = start_dir_i;
`else
   assign first_dir = 1'b1;
`endif

   always_comb begin
      timer_d  = timer_q + 1'b1;
      sweeps_d = sweeps_q + 1'b1;
      skip_d   = (&skip_q) ? skip_q : skip_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         num_q      <= '0;
         timer_q    <= '0;
         blank_q    <= 1'b0;
         cnt_rst_q  <= 1'b0;
         cnt_mode_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         sweeps_q   <= '0;
         skip_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  error_q <= 1'b0;
                  if (num_sweeps_i == '0) begin
                     // Nothing to sweep: report completion, leave counts alone.
                     done_q <= 1'b1;
                  end else begin
                     state_q    <= S_CLR;
                     num_q      <= num_sweeps_i;
                     sweeps_q   <= '0;
                     skip_q     <= '0;
                     timer_q    <= '0;
                     cnt_rst_q  <= 1'b1;
                     cnt_mode_q <= first_dir;
                     busy_q     <= 1'b1;
                  end
               end
            end
            S_CLR: begin
               cnt_rst_q <= 1'b0;
               if (abort_i) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_RUN;
                  blank_q <= 1'b1;
               end
            end
            S_RUN: begin
               if (abort_i) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  timer_q <= timer_d;
                  blank_q <= 1'b0;
                  // Counter flags lag one cycle, so they are ignored right
                  // after a clear or a direction change.
                  if (!blank_q) begin
                     if (!cnt_skip_i) skip_q <= skip_d;
                     if (!cnt_limit_i) begin
                        sweeps_q <= sweeps_d;
                        timer_q  <= '0;
                        if (sweeps_d == num_q) begin
                           done_q  <= 1'b1;
                           state_q <= S_IDLE;
                           busy_q  <= 1'b0;
                        end else begin
                           cnt_mode_q <= ~cnt_mode_q;
                           blank_q    <= 1'b1;
                        end
                     end
                  end
                  // A limit seen this cycle restarts the half-sweep instead.
                  if ((blank_q || cnt_limit_i) && timer_d == TMAX) begin
                     state_q <= S_ERR;
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            S_ERR: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cnt_rst_o     = cnt_rst_q;
   assign cnt_mode_o    = cnt_mode_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign sweeps_done_o = sweeps_q;
   assign skip_count_o  = skip_q;

endmodule

// File: tb/tb_counter_sweep_seq.sv
// Directed bench for counter_sweep_seq: a vector table for the main sweep,
// saturation and zero-sweep cases, plus hand-written timeout, abort,
// busy-start and asynchronous reset sequences.
module tb_counter_sweep_seq;
   localparam int SW = 8;
   localparam int KW = 2;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst, start, abort, limit, skip;
   logic [SW-1:0] ns;
   logic          start_dir;
   logic          cnt_rst, cnt_mode, busy, done, error;
   logic [SW-1:0] sweeps;
   logic [KW-1:0] skips;

   counter_sweep_seq #(.SWEEP_W(SW), .SKIP_W(KW), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .num_sweeps_i(ns),
`ifdef SEQ_START_DIR_EN
      .start_dir_i(start_dir),
`endif
      .cnt_limit_i(limit), .cnt_skip_i(skip),
      .cnt_rst_o(cnt_rst), .cnt_mode_o(cnt_mode), .busy_o(busy),
      .done_o(done), .error_o(error), .sweeps_done_o(sweeps),
      .skip_count_o(skips));

   always #5 clk = ~clk;

   typedef struct {
      logic          st, ab, lim, skp;
      logic [SW-1:0] n;
      logic [14:0]   exp;
   } vec_t;

   vec_t vq[$];
   int   errs = 0;
   int   checks = 0;

   function automatic logic [14:0] ex(int r, int m, int b, int d, int e, int sw, int sk);
      return {1'(r), 1'(m), 1'(b), 1'(d), 1'(e), 8'(sw), 2'(sk)};
   endfunction

   function automatic vec_t mk(int st, int ab, int n, int lim, int skp, logic [14:0] e);
      vec_t v;
      v.st = 1'(st); v.ab = 1'(ab); v.n = 8'(n); v.lim = 1'(lim); v.skp = 1'(skp);
      v.exp = e;
      return v;
   endfunction

   function automatic logic [14:0] obs();
      return {cnt_rst, cnt_mode, busy, done, error, sweeps, skips};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      start = 0; abort = 0; ns = 0; limit = 1; skip = 1; start_dir = 1;
   endtask

   initial begin
      rst = 1;
      idle_in();
      // two-sweep run, skips, blank cycles
      vq.push_back(mk(1,0,2,1,1, ex(1,1,1,0,0,0,0)));
      vq.push_back(mk(0,0,0,1,1, ex(0,1,1,0,0,0,0)));
      vq.push_back(mk(0,0,0,1,0, ex(0,1,1,0,0,0,0)));   // blank: skip ignored
      vq.push_back(mk(0,0,0,1,1, ex(0,1,1,0,0,0,0)));
      vq.push_back(mk(0,0,0,1,0, ex(0,1,1,0,0,0,1)));
      for (int i = 0; i < 7; i++) vq.push_back(mk(0,0,0,1,1, ex(0,1,1,0,0,0,1)));
      vq.push_back(mk(0,0,0,0,1, ex(0,0,1,0,0,1,1)));   // first limit
      vq.push_back(mk(0,0,0,0,0, ex(0,0,1,0,0,1,1)));   // blank: both ignored
      for (int i = 0; i < 3; i++) vq.push_back(mk(0,0,0,1,1, ex(0,0,1,0,0,1,1)));
      vq.push_back(mk(0,0,0,0,0, ex(0,0,0,1,0,2,2)));   // limit+skip, done
      vq.push_back(mk(0,0,0,1,1, ex(0,0,0,0,0,2,2)));
      // zero-sweep start
      vq.push_back(mk(1,0,0,1,1, ex(0,0,0,1,0,2,2)));
      vq.push_back(mk(0,0,0,1,1, ex(0,0,0,0,0,2,2)));
      // start+abort in IDLE: start wins; skip saturation
      vq.push_back(mk(1,1,1,1,1, ex(1,1,1,0,0,0,0)));
      vq.push_back(mk(0,0,0,1,1, ex(0,1,1,0,0,0,0)));
      vq.push_back(mk(0,0,0,1,0, ex(0,1,1,0,0,0,0)));
      vq.push_back(mk(0,0,0,1,0, ex(0,1,1,0,0,0,1)));
      vq.push_back(mk(0,0,0,1,0, ex(0,1,1,0,0,0,2)));
      vq.push_back(mk(0,0,0,1,0, ex(0,1,1,0,0,0,3)));
      vq.push_back(mk(0,0,0,1,0, ex(0,1,1,0,0,0,3)));
      vq.push_back(mk(0,0,0,1,0, ex(0,1,1,0,0,0,3)));
      vq.push_back(mk(0,0,0,0,1, ex(0,1,0,1,0,1,3)));
      vq.push_back(mk(0,0,0,1,1, ex(0,1,0,0,0,1,3)));

      step(); step();
      chk("reset_state", 32'(obs()), 32'(ex(0,1,0,0,0,0,0)));
      rst = 0;
      step();
      chk("after_release", 32'(obs()), 32'(ex(0,1,0,0,0,0,0)));

      foreach (vq[i]) begin
         start = vq[i].st; abort = vq[i].ab; ns = vq[i].n;
         limit = vq[i].lim; skip = vq[i].skp;
         step();
         chk($sformatf("vec%0d", i), 32'(obs()), 32'(vq[i].exp));
      end
      idle_in();

      // timeout: limit never drops
      start = 1; ns = 3;
      step();
      start = 0;
      chk("to_clr", 32'({cnt_rst, busy}), 32'(2'b11));
      step();
      for (int k = 1; k <= 15; k++) begin
         step();
         chk($sformatf("to_run%0d", k), 32'({busy, error, cnt_mode}),
             (k < 15) ? 32'(3'b101) : 32'(3'b011));
      end
      step();
      chk("to_sticky", 32'({busy, error}), 32'(2'b01));
      step();
      chk("to_sticky2", 32'({busy, error}), 32'(2'b01));
      start = 1; ns = 3;
      step();
      start = 0;
      chk("to_restart", 32'({cnt_rst, busy, error}), 32'(3'b110));
      abort = 1;
      step();
      abort = 0;
      chk("abort_clr", 32'({cnt_rst, busy, done}), 32'(3'b000));

      // start while busy, then abort racing a limit
      start = 1; ns = 2;
      step(); step();
      start = 1; ns = 1;
      step();                        // blank cycle; start ignored
      chk("busy_start", 32'({cnt_rst, busy}), 32'(2'b01));
      start = 0;
      limit = 0; abort = 1;
      step();
      chk("abort_limit", 32'({busy, done, sweeps}), 32'({2'b00, 8'd0}));
      limit = 1; abort = 0;
      step();
      chk("abort_after", 32'({busy, done, sweeps}), 32'({2'b00, 8'd0}));

      // asynchronous reset in the second half-sweep
      start = 1; ns = 2;
      step();
      start = 0;
      step();
      skip = 0;
      step(); step();
      skip = 1; limit = 0;
      step();
      limit = 1;
      chk("pre_rst", 32'(obs()), 32'(ex(0,0,1,0,0,1,1)));
      #3 rst = 1;
      #1;
      chk("async_rst", 32'(obs()), 32'(ex(0,1,0,0,0,0,0)));
      rst = 0;
      step();
      chk("post_rst", 32'(obs()), 32'(ex(0,1,0,0,0,0,0)));

`ifdef SEQ_START_DIR_EN
      start = 1; ns = 1; start_dir = 0;
      step();
      start = 0;
      chk("start_dir0", 32'({cnt_rst, cnt_mode}), 32'(2'b10));
      abort = 1;
      step();
      abort = 0;
`else
      start = 1; ns = 1;
      step();
      start = 0;
      chk("start_dir_up", 32'({cnt_rst, cnt_mode}), 32'(2'b11));
      abort = 1;
      step();
      abort = 0;
`endif
      chk("final_idle", 32'({busy, done}), 32'(2'b00));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
